// File: rtl/axil_uart_ctrl.sv
// AXI-lite master that programs a 16550-style UART after reset and
// then streams bytes into THR, polling LSR.THRE before each byte.
module axil_uart_ctrl #(
  parameter int          ADDR_W    = 30,
  parameter int          REG_SHIFT = 2,
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter logic [7:0]  LCR_VAL   = 8'h03,
  parameter logic [7:0]  FCR_VAL   = 8'hC7,
  parameter logic [7:0]  IER_VAL   = 8'h00
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              init_done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  output logic [2:0]        m_axil_awprot,
  output logic              m_axil_awvalid,
  input  logic              m_axil_awready,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  output logic              m_axil_wvalid,
  input  logic              m_axil_wready,
  input  logic [1:0]        m_axil_bresp,
  input  logic              m_axil_bvalid,
  output logic              m_axil_bready,
  output logic [ADDR_W-1:0] m_axil_araddr,
  output logic [2:0]        m_axil_arprot,
  output logic              m_axil_arvalid,
  input  logic              m_axil_arready,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp,
  input  logic              m_axil_rvalid,
  output logic              m_axil_rready
);

  typedef enum logic [2:0] {
    INIT_AW, INIT_B, IDLE, POLL_AR, POLL_R, THR_AW, THR_B
  } state_t;

  localparam logic [ADDR_W-1:0] LSR_ADDR = ADDR_W'(5) << REG_SHIFT;
  localparam logic [ADDR_W-1:0] THR_ADDR = '0;

  state_t            r_state;
  logic [2:0]        r_idx;
  logic [7:0]        r_byte;
  logic              r_tx_ready;
  logic              r_init_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_awaddr;
  logic [ADDR_W-1:0] r_araddr;
  logic [31:0]       r_wdata;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;

  logic [10:0]       w_init;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_aw_ok;
  logic              w_w_ok;
  logic              w_wr_done;
  logic              w_unused;

  function automatic logic [10:0] f_init(input logic [2:0] i);
    unique case (i)
      3'd0:    return {3'd3, 8'h80 | LCR_VAL};
      3'd1:    return {3'd0, DIVISOR[7:0]};
      3'd2:    return {3'd1, DIVISOR[15:8]};
      3'd3:    return {3'd3, LCR_VAL};
      3'd4:    return {3'd2, FCR_VAL};
      default: return {3'd1, IER_VAL};
    endcase
  endfunction

  assign w_init      = f_init(r_idx);
  assign w_init_addr = ADDR_W'(w_init[10:8]) << REG_SHIFT;
  // each channel is done once its valid is already low or handshakes now
  assign w_aw_ok     = ~r_awvalid | m_axil_awready;
  assign w_w_ok      = ~r_wvalid | m_axil_wready;
  assign w_wr_done   = w_aw_ok & w_w_ok;
  assign w_unused    = ^{m_axil_rdata[31:6], m_axil_rdata[4:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= INIT_AW;
      r_idx       <= '0;
      r_byte      <= '0;
      r_tx_ready  <= 1'b0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      unique case (r_state)
        INIT_AW: begin
          if (!r_awvalid && !r_wvalid) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= w_init_addr;
            r_wdata   <= {24'h0, w_init[7:0]};
          end else begin
            if (m_axil_awready) r_awvalid <= 1'b0;
            if (m_axil_wready)  r_wvalid  <= 1'b0;
            if (w_wr_done) begin
              r_bready <= 1'b1;
              r_state  <= INIT_B;
            end
          end
        end
        INIT_B: begin
          if (m_axil_bvalid) begin
            r_bready <= 1'b0;
            if (m_axil_bresp != 2'b00) r_err <= 1'b1;
            if (r_idx == 3'd5) begin
              r_init_done <= 1'b1;
              r_tx_ready  <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= INIT_AW;
            end
          end
        end
        IDLE: begin
          if (tx_valid_i && r_tx_ready) begin
            r_tx_ready <= 1'b0;
            r_byte     <= tx_data_i;
            r_arvalid  <= 1'b1;
            r_araddr   <= LSR_ADDR;
            r_state    <= POLL_AR;
          end
        end
        POLL_AR: begin
          if (m_axil_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= POLL_R;
          end
        end
        POLL_R: begin
          if (m_axil_rvalid) begin
            r_rready <= 1'b0;
            if (m_axil_rresp != 2'b00) r_err <= 1'b1;
            if (m_axil_rdata[5]) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= THR_ADDR;
              r_wdata   <= {24'h0, r_byte};
              r_state   <= THR_AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= POLL_AR;
            end
          end
        end
        THR_AW: begin
          if (m_axil_awready) r_awvalid <= 1'b0;
          if (m_axil_wready)  r_wvalid  <= 1'b0;
          if (w_wr_done) begin
            r_bready <= 1'b1;
            r_state  <= THR_B;
          end
        end
        THR_B: begin
          if (m_axil_bvalid) begin
            r_bready   <= 1'b0;
            if (m_axil_bresp != 2'b00) r_err <= 1'b1;
            r_tx_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= INIT_AW;
      endcase
    end
  end

  assign tx_ready_o     = r_tx_ready;
  assign init_done_o    = r_init_done;
  assign err_o          = r_err;
  assign m_axil_awaddr  = r_awaddr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = 4'hF;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = r_bready;
  assign m_axil_araddr  = r_araddr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_axil_uart_ctrl.sv
// Bench for axil_uart_ctrl: AXI-lite slave model plus a scoreboard
// monitor that checks every write/read against queued expectations.
module tb_axil_uart_ctrl;

  logic        clk;
  logic        rst_ni;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        init_done_o;
  logic        err_o;
  logic [29:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [29:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  axil_uart_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .init_done_o(init_done_o), .err_o(err_o),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot),
    .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot),
    .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [61:0] exp_wr[$];
  logic [29:0] exp_rd[$];
  logic [31:0] lsr_q[$];

  // slave configuration
  int aw_lat = 0;
  int w_lat  = 0;
  int err_wr = -1;

  // slave model: readies/valids change at posedge+1, handshakes
  // are decided at negedge while everything is stable
  logic s_hs_aw, s_hs_w, s_hs_b, s_hs_ar, s_hs_r;
  logic got_aw, got_w;
  int   cnt_aw, cnt_w, wr_cnt;

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    got_aw = 0; got_w = 0; cnt_aw = 0; cnt_w = 0; wr_cnt = 0;
    forever begin
      @(negedge clk);
      s_hs_aw = awvalid & awready;
      s_hs_w  = wvalid & wready;
      s_hs_b  = bvalid & bready;
      s_hs_ar = arvalid & arready;
      s_hs_r  = rvalid & rready;
      @(posedge clk);
      #1;
      if (!rst_ni) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0;
        got_aw = 0; got_w = 0; cnt_aw = 0; cnt_w = 0; wr_cnt = 0;
      end else begin
        if (s_hs_b) begin
          bvalid = 0; got_aw = 0; got_w = 0; wr_cnt++;
        end
        if (s_hs_aw) begin
          awready = 0; got_aw = 1; cnt_aw = 0;
        end else if (awvalid && !awready) begin
          if (cnt_aw >= aw_lat) awready = 1;
          else cnt_aw++;
        end
        if (s_hs_w) begin
          wready = 0; got_w = 1; cnt_w = 0;
        end else if (wvalid && !wready) begin
          if (cnt_w >= w_lat) wready = 1;
          else cnt_w++;
        end
        if (got_aw && got_w && !bvalid) begin
          bvalid = 1;
          bresp  = (wr_cnt == err_wr) ? 2'b10 : 2'b00;
        end
        if (s_hs_r) rvalid = 0;
        if (s_hs_ar) begin
          arready = 0;
          rvalid  = 1;
          rdata   = (lsr_q.size() > 0) ? lsr_q.pop_front() : 32'h60;
        end else if (arvalid && !arready) begin
          arready = 1;
        end
      end
    end
  end

  // monitor / scoreboard
  logic [29:0] cap_addr;
  logic [31:0] cap_data;
  logic        p_aw_pend, p_w_pend, p_awv, err_pend;
  logic [29:0] p_awaddr;
  logic [31:0] p_wdata;
  int          b_cnt = 0;
  logic        saw_w_first, saw_aw_first;

  initial begin
    p_aw_pend = 0; p_w_pend = 0; p_awv = 0; err_pend = 0;
    saw_w_first = 0; saw_aw_first = 0;
  end

  always @(negedge clk) begin
    if (!rst_ni) begin
      p_aw_pend = 0; p_w_pend = 0; p_awv = 0; err_pend = 0;
    end else begin
      if (err_pend) chk("err_next_cycle", err_o, 1);
      err_pend = 0;
      if (p_aw_pend) chk("aw_held", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_w_pend)  chk("w_held", {wvalid, wdata}, {1'b1, p_wdata});
      if (!p_awv && awvalid) chk("aw_w_rise", wvalid, 1);
      if (bready) chk("bready_after_both", {awvalid, wvalid}, 0);
      if (awvalid && !wvalid) saw_w_first = 1;
      if (wvalid && !awvalid) saw_aw_first = 1;
      if (awvalid && awready) begin
        cap_addr = awaddr;
        chk("awprot", awprot, 0);
      end
      if (wvalid && wready) begin
        cap_data = wdata;
        chk("wstrb", wstrb, 4'hF);
      end
      if (bvalid && bready) begin
        b_cnt++;
        if (bresp != 2'b00) err_pend = 1;
        if (exp_wr.size() == 0)
          chk("unexpected_write", {cap_addr, cap_data}, 62'h0);
        else
          chk("write", {cap_addr, cap_data}, exp_wr.pop_front());
      end
      if (arvalid && arready) begin
        chk("arprot", arprot, 0);
        if (exp_rd.size() == 0) chk("unexpected_read", araddr, 30'h3FFFFFFF);
        else chk("read_addr", araddr, exp_rd.pop_front());
      end
      p_aw_pend = awvalid & ~awready;
      p_w_pend  = wvalid & ~wready;
      p_awaddr  = awaddr;
      p_wdata   = wdata;
      p_awv     = awvalid;
    end
  end

  task automatic push_init();
    exp_wr.push_back({30'h0C, 32'h83});
    exp_wr.push_back({30'h00, 32'h1B});
    exp_wr.push_back({30'h04, 32'h00});
    exp_wr.push_back({30'h0C, 32'h03});
    exp_wr.push_back({30'h08, 32'hC7});
    exp_wr.push_back({30'h04, 32'h00});
  endtask

  task automatic wait_init();
    int k = 0;
    @(negedge clk);
    while (!init_done_o && k < 300) begin @(negedge clk); k++; end
    chk("init_done", init_done_o, 1);
    chk("tx_ready_after_init", tx_ready_o, 1);
    chk("init_writes_left", exp_wr.size(), 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    tx_data_i  = b;
    tx_valid_i = 1;
    while (!tx_ready_o && k < 50) begin @(negedge clk); k++; end
    chk("tx_accept", tx_ready_o, 1);
    @(posedge clk);
    #1;
    tx_valid_i = 0;
    tx_data_i  = 8'hFF;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge clk);
    while (!tx_ready_o && k < 200) begin @(negedge clk); k++; end
    chk({nm, "_idle"}, tx_ready_o, 1);
    chk({nm, "_wr_left"}, exp_wr.size(), 0);
    chk({nm, "_rd_left"}, exp_rd.size(), 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_ni = 0;
    repeat (3) @(negedge clk);
    rst_ni = 1;
  endtask

  int b0;

  initial begin
    rst_ni = 0; tx_data_i = 0; tx_valid_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_status", {tx_ready_o, init_done_o, err_o}, 0);
    chk("rst_addr_data", {awaddr, araddr, wdata}, 0);

    // 1: init sequence
    push_init();
    rst_ni = 1;
    wait_init();
    chk("no_err_after_init", err_o, 0);

    // 2: single byte, THRE already set
    exp_rd.push_back(30'h14);
    lsr_q.push_back(32'h60);
    exp_wr.push_back({30'h0, 32'h41});
    send_byte(8'h41);
    wait_idle("byte41");

    // 3: THRE clear twice, then set
    lsr_q.push_back(32'h00); lsr_q.push_back(32'h00);
    lsr_q.push_back(32'h20);
    repeat (3) exp_rd.push_back(30'h14);
    exp_wr.push_back({30'h0, 32'h5A});
    send_byte(8'h5A);
    wait_idle("poll_retry");

    // 4a: W completes before AW
    aw_lat = 3; w_lat = 0;
    saw_w_first = 0; b0 = b_cnt;
    exp_rd.push_back(30'h14); lsr_q.push_back(32'h20);
    exp_wr.push_back({30'h0, 32'h33});
    send_byte(8'h33);
    wait_idle("w_first");
    chk("w_first_split", saw_w_first, 1);
    chk("w_first_bcnt", b_cnt - b0, 1);

    // 4b: AW completes before W
    aw_lat = 0; w_lat = 3;
    saw_aw_first = 0; b0 = b_cnt;
    exp_rd.push_back(30'h14); lsr_q.push_back(32'h20);
    exp_wr.push_back({30'h0, 32'hCC});
    send_byte(8'hCC);
    wait_idle("aw_first");
    chk("aw_first_split", saw_aw_first, 1);
    chk("aw_first_bcnt", b_cnt - b0, 1);
    w_lat = 0;

    // 5: error response on second init write
    err_wr = 1;
    push_init();
    reset_pulse();
    wait_init();
    chk("err_sticky", err_o, 1);
    err_wr = -1;

    // 6: reset while THR write pending
    aw_lat = 20; w_lat = 20;
    exp_rd.push_back(30'h14); lsr_q.push_back(32'h20);
    send_byte(8'h77);
    begin
      int k = 0;
      @(negedge clk);
      while (!awvalid && k < 50) begin @(negedge clk); k++; end
      chk("thr_aw_pending", {awvalid, wvalid}, 2'b11);
    end
    #2 rst_ni = 0;
    #1;
    chk("async_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("async_status", {tx_ready_o, init_done_o, err_o}, 0);
    exp_wr.delete(); exp_rd.delete(); lsr_q.delete();
    aw_lat = 0; w_lat = 0;
    repeat (3) @(negedge clk);
    push_init();
    rst_ni = 1;
    wait_init();
    chk("err_after_reset", err_o, 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_uart_ctrl.md
Name: axil_uart_ctrl

Overview:
AXI-lite master controller that sequences the AXI-lite 16550-style UART peripheral (axil_uart_top). After reset it programs the baud divisor, line control, FIFO control and interrupt enable registers over AXI-lite. It then serves a byte-stream transmit interface: it polls LSR until THRE is set, then writes each byte to THR. It sits between a boot/console byte source and the UART's s_axil_* slave port.

Parameters:
ADDR_W, 30, AXI-lite address width.
REG_SHIFT, 2, byte address = register index << REG_SHIFT (e.g. LCR = index 3 -> 0xC).
DIVISOR, 16'd27, baud divisor written to DLL/DLM.
LCR_VAL, 8'h03, final LCR value (8N1, DLAB=0).
FCR_VAL, 8'hC7, FIFO control value.
IER_VAL, 8'h00, interrupt enable value.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
tx_data_i  in  8  byte to transmit
tx_valid_i  in  1  byte valid
tx_ready_o  out  1  byte accepted when tx_valid_i & tx_ready_o
init_done_o  out  1  init sequence complete (sticky until reset)
err_o  out  1  sticky: any BRESP/RRESP != 2'b00 seen
m_axil_awaddr  out  ADDR_W  write address
m_axil_awprot  out  3  always 3'b000
m_axil_awvalid  out  1
m_axil_awready  in  1
m_axil_wdata  out  32  {24'h0, byte}
m_axil_wstrb  out  4  always 4'hF
m_axil_wvalid  out  1
m_axil_wready  in  1
m_axil_bresp  in  2
m_axil_bvalid  in  1
m_axil_bready  out  1
m_axil_araddr  out  ADDR_W  read address
m_axil_arprot  out  3  always 3'b000
m_axil_arvalid  out  1
m_axil_arready  in  1
m_axil_rdata  in  32
m_axil_rresp  in  2
m_axil_rvalid  in  1
m_axil_rready  out  1

Behaviour:
- Reset (rst_ni=0, async): state=INIT_AW, init index=0. All valid/ready outputs, init_done_o and err_o are 0. Addresses and data hold 0.
- Reset mid-transaction: all state is abandoned immediately; the init sequence restarts from index 0 on deassertion.
- Init sequence, in order (register index, data):
  - (3, 8'h80|LCR_VAL)
  - (0, DIVISOR[7:0])
  - (1, DIVISOR[15:8])
  - (3, LCR_VAL)
  - (2, FCR_VAL)
  - (1, IER_VAL)
- Write transaction, used for init and THR:
  - AWVALID and WVALID rise in the same cycle.
  - Each is held until its own handshake, then dropped independently. AW and W may complete in either order or in the same cycle.
  - When both are done, BREADY=1 until BVALID. Addr/data stay stable while valid is high.
- Read transaction:
  - ARVALID held until ARREADY.
  - RREADY=1 in the following R state until RVALID.
- Any BRESP/RRESP != 0 sets err_o. The sequence continues regardless; the response is not retried.
- States and transitions:
  - INIT_AW -> INIT_B: after the 6th B handshake, init_done_o=1 and go to IDLE; otherwise index+1 and back to INIT_AW.
  - IDLE: tx_ready_o=1 only here and only when init_done_o=1. On a tx handshake, latch the byte and go to POLL_AR.
  - POLL_AR -> POLL_R (read LSR, index 5, addr 5<<REG_SHIFT).
  - POLL_R: on RVALID, if rdata[5] (THRE)=1 go to THR_AW, else go to POLL_AR (unbounded retry).
  - THR_AW -> THR_B (write latched byte to index 0) -> IDLE.
- Minimum per-byte cost with zero-wait slave: 2 cycles AR/R plus 2 cycles AW+W/B; one byte accepted at most every 5 cycles.
- tx_valid_i is ignored outside IDLE; the latched byte is unaffected by tx_data_i changes.

Test Plan:
1. Release reset with an always-ready slave -> exactly 6 writes observed, in order:
   - 0xC/0x83
   - 0x0/0x1B
   - 0x4/0x00
   - 0xC/0x03
   - 0x8/0xC7
   - 0x4/0x00
   Then init_done_o=1 and tx_ready_o=1.
2. Send byte 0x41 with LSR read = 0x60 -> one read at 0x14, then a write to 0x0 with wdata=0x00000041, wstrb=0xF; back to IDLE with tx_ready_o=1.
3. LSR returns 0x00, 0x00, then 0x20 -> exactly 3 AR handshakes at 0x14 before a single THR write of the latched byte.
4. Slave asserts WREADY 3 cycles before AWREADY, then the reverse case -> WVALID drops after its handshake, AWVALID stays high until its own; BREADY rises only after both; exactly one B accepted.
5. Slave returns BRESP=2'b10 on the 2nd init write -> err_o=1 from the next cycle and stays 1; the remaining 4 init writes are still issued.
6. Assert rst_ni low while THR_AW is pending -> all valids drop asynchronously and err_o/init_done_o clear; after release the first write is 0xC/0x83.
